// File: rtl/cntseq_pkg.sv
// cntseq_pkg: shared command opcodes and sequencer states for counter_cmd_sequencer.
// Contents:
//   cmd_op_e    - command opcode carried on cmd_op (LOAD, UP, DOWN, WAIT)
//   seq_state_e - sequencer FSM state (IDLE, STEP, DONE)
//   CNTSEQ_N    - default counter/argument width
// The {op, arg} command struct is declared inside each module so that its
// argument field follows that module's N parameter.
package cntseq_pkg;

   localparam int unsigned CNTSEQ_N = 8;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_UP   = 2'd1,
      OP_DOWN = 2'd2,
      OP_WAIT = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/cntseq_cmd_buf.sv
// cntseq_cmd_buf: one-entry command holding slot for counter_cmd_sequencer.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   flush             - drop the held entry
//   wr, wr_data       - store an entry (only issued while the slot is empty)
//   rd                - release the held entry
//   full, rd_data     - slot occupied flag and held entry
module cntseq_cmd_buf
   import cntseq_pkg::*;
#(
   parameter int W = CNTSEQ_N + 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         wr,
   input  logic [W-1:0] wr_data,
   input  logic         rd,
   output logic         full,
   output logic [W-1:0] rd_data
);

   always_ff @(posedge clk) begin
      if (reset || flush) full <= 1'b0;
      else if (wr)        full <= 1'b1;
      else if (rd)        full <= 1'b0;
      if (reset)   rd_data <= '0;
      else if (wr) rd_data <= wr_data;
   end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: expands LOAD/UP/DOWN/WAIT commands into per-cycle counter strobes.
// Optional feature: define CNTSEQ_CMD_BUF_EN to add a one-entry command buffer
// that lets a new command be accepted while one is executing.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake
//   cmd_op, cmd_arg       - opcode and argument (load value or step count K)
//   abort                 - cancel the running command and any buffered command
//   ctr_en, ctr_up_down, ctr_load, ctr_load_val - counter control strobes
//   busy, done, aborted   - status: not idle, completion pulse, abort acknowledge
//   steps_left            - steps remaining in the current command
module counter_cmd_sequencer
   import cntseq_pkg::*;
#(
   parameter int N = CNTSEQ_N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_arg,
   input  logic         abort,
   output logic         ctr_en,
   output logic         ctr_up_down,
   output logic         ctr_load,
   output logic [N-1:0] ctr_load_val,
   output logic         busy,
   output logic         done,
   output logic         aborted,
   output logic [N-1:0] steps_left
);

   typedef struct packed {
      cmd_op_e      op;
      logic [N-1:0] arg;
   } cmd_t;

   seq_state_e   state, state_n;
   cmd_t         cur, in_cmd, launch, buf_data;
   logic [N-1:0] steps_n, launch_k;
   logic         accept, go, buf_full, up_down_q, step;

   assign in_cmd = '{op: cmd_op_e'(cmd_op), arg: cmd_arg};
   assign accept = cmd_valid && cmd_ready;

`ifdef CNTSEQ_CMD_BUF_EN
   assign cmd_ready = !buf_full && !reset && !abort;

   // Commands arriving during STEP wait in the slot; outside STEP they start directly.
   cntseq_cmd_buf #(.W($bits(cmd_t))) u_buf (
      .clk     (clk),
      .reset   (reset),
      .flush   (abort),
      .wr      (accept && state == S_STEP),
      .wr_data (in_cmd),
      .rd      (go && buf_full),
      .full    (buf_full),
      .rd_data (buf_data)
   );
`else
   assign cmd_ready = state == S_IDLE && !reset && !abort;
   assign buf_full  = 1'b0;
   assign buf_data  = '0;
`endif

   // A held command has priority over the one on the interface.
   assign go       = state != S_STEP && !abort && (buf_full || accept);
   assign launch   = buf_full ? buf_data : in_cmd;
   assign launch_k = launch.op == OP_LOAD ? N'(1) : launch.arg;

   always_comb begin
      state_n = state;
      steps_n = steps_left;
      if (abort && state != S_IDLE) begin
         state_n = S_IDLE;
         steps_n = '0;
      end else if (go) begin
         state_n = launch_k == '0 ? S_DONE : S_STEP;
         steps_n = launch_k;
      end else if (state == S_STEP) begin
         state_n = steps_left == N'(1) ? S_DONE : S_STEP;
         steps_n = steps_left - N'(1);
      end else if (state == S_DONE) begin
         state_n = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         steps_left <= '0;
         cur        <= '0;
         up_down_q  <= 1'b1;
         aborted    <= 1'b0;
      end else begin
         state      <= state_n;
         steps_left <= steps_n;
         aborted    <= abort && state != S_IDLE;
         if (go) cur <= launch;
         // Direction only changes when an UP/DOWN burst actually starts.
         if (go && launch_k != '0 && (launch.op == OP_UP || launch.op == OP_DOWN))
            up_down_q <= launch.op == OP_UP;
      end
   end

   assign step         = state == S_STEP;
   assign ctr_en       = step && cur.op != OP_WAIT;
   assign ctr_load     = step && cur.op == OP_LOAD;
   assign ctr_load_val = ctr_load ? cur.arg : '0;
   assign ctr_up_down  = up_down_q;
   assign busy         = state != S_IDLE;
   assign done         = state == S_DONE;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: directed self-checking bench for counter_cmd_sequencer.
module tb_counter_cmd_sequencer;
   import cntseq_pkg::*;

   logic       clk = 1'b0;
   logic       reset, cmd_valid, abort;
   logic [1:0] cmd_op;
   logic [7:0] cmd_arg;
   logic       cmd_ready, ctr_en, ctr_up_down, ctr_load, busy, done, aborted;
   logic [7:0] ctr_load_val, steps_left;
   logic [7:0] cnt;
   int         checks = 0;
   int         errors = 0;

   counter_cmd_sequencer #(.N(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_arg      (cmd_arg),
      .abort        (abort),
      .ctr_en       (ctr_en),
      .ctr_up_down  (ctr_up_down),
      .ctr_load     (ctr_load),
      .ctr_load_val (ctr_load_val),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .steps_left   (steps_left)
   );

   always #5 clk = ~clk;

   // Reference counter driven by the strobes.
   always_ff @(posedge clk) begin
      if (reset)         cnt <= '0;
      else if (ctr_en)   cnt <= ctr_load ? ctr_load_val : ctr_up_down ? cnt + 8'd1 : cnt - 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents one command for exactly one edge; returns in the first cycle after acceptance.
   task automatic send(input logic [1:0] op, input logic [7:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      #1 check("send_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 8'd5; abort = 1'b0;
      repeat (3) tick();
      check("rst_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_en", ctr_en, 0);
      check("rst_load", ctr_load, 0);
      check("rst_lval", ctr_load_val, 0);
      check("rst_ud", ctr_up_down, 1);
      check("rst_done", done, 0);
      check("rst_abt", aborted, 0);
      check("rst_steps", steps_left, 0);
      reset = 1'b0; cmd_valid = 1'b0;
      #1 check("post_rst_ready", cmd_ready, 1);
      tick();
      check("post_rst_idle", busy, 0);

      send(OP_UP, 8'd3);
      for (int i = 0; i < 3; i++) begin
         check("up_en", ctr_en, 1);
         check("up_dir", ctr_up_down, 1);
         check("up_steps", steps_left, 3 - i);
         check("up_ready", cmd_ready, 0);
         tick();
      end
      check("up_done", done, 1);
      check("up_done_en", ctr_en, 0);
      tick();
      check("up_idle_ready", cmd_ready, 1);
      check("up_idle_done", done, 0);
      send(OP_DOWN, 8'd2);
      for (int i = 0; i < 2; i++) begin
         check("dn_en", ctr_en, 1);
         check("dn_dir", ctr_up_down, 0);
         tick();
      end
      check("dn_done", done, 1);
      check("dn_done_en", ctr_en, 0);
      tick();
      check("cnt_after_up_dn", cnt, 1);
      check("dir_hold", ctr_up_down, 0);

      send(OP_UP, 8'd0);
      check("k0_done", done, 1);
      check("k0_en", ctr_en, 0);
      check("k0_dir_hold", ctr_up_down, 0);
      tick();
      check("k0_idle", busy, 0);

      send(OP_WAIT, 8'd4);
      for (int i = 0; i < 4; i++) begin
         check("wait_busy", busy, 1);
         check("wait_en", ctr_en, 0);
         check("wait_steps", steps_left, 4 - i);
         tick();
      end
      check("wait_done", done, 1);
      tick();
      check("wait_idle", busy, 0);

      send(OP_LOAD, 8'hA5);
      check("ld_en", ctr_en, 1);
      check("ld_load", ctr_load, 1);
      check("ld_val", ctr_load_val, 8'hA5);
      check("ld_steps", steps_left, 1);
      tick();
      check("ld_done", done, 1);
      check("ld_val_off", ctr_load_val, 0);
      check("ld_ready_T2", cmd_ready, 0);
      tick();
      check("ld_ready_T3", cmd_ready, 1);
      check("cnt_after_ld", cnt, 8'hA5);

      send(OP_DOWN, 8'd10);
      repeat (3) tick();
      check("ab_4th_en", ctr_en, 1);
      check("ab_4th_steps", steps_left, 7);
      abort = 1'b1;
      #1 check("ab_ready_low", cmd_ready, 0);
      tick();
      abort = 1'b0;
      #1;
      check("ab_en", ctr_en, 0);
      check("ab_pulse", aborted, 1);
      check("ab_no_done", done, 0);
      check("ab_busy", busy, 0);
      check("ab_ready", cmd_ready, 1);
      tick();
      check("ab_pulse_end", aborted, 0);
      check("ab_no_done2", done, 0);
      check("cnt_after_ab", cnt, 8'hA1);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      #1 check("idle_abort", aborted, 0);
      tick();

`ifdef CNTSEQ_CMD_BUF_EN
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 8'd2;
      tick();
      check("buf_ready_T1", cmd_ready, 1);
      check("buf_up_en", ctr_en, 1);
      cmd_op = OP_LOAD; cmd_arg = 8'h3C;
      tick();
      cmd_valid = 1'b0;
      #1;
      check("buf_full_ready", cmd_ready, 0);
      check("buf_up_en2", ctr_en, 1);
      check("buf_up_dir", ctr_up_down, 1);
      tick();
      check("buf_up_done", done, 1);
      check("buf_gap_en", ctr_en, 0);
      tick();
      check("buf_ld_en", ctr_load, 1);
      check("buf_ld_val", ctr_load_val, 8'h3C);
      tick();
      check("buf_ld_done", done, 1);
      tick();
      check("buf_idle", busy, 0);
      check("cnt_after_buf", cnt, 8'h3C);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion before 100000");
      $fatal(1);
   end

endmodule
